// File: rtl/hazard_ctrl_pkg.sv
// Shared pipeline definitions for the hazard controller: register-address
// width, FSM state encoding and the EX-stage shadow record.
package hazard_ctrl_pkg;

  localparam int REG_ADDR_W = 3;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  typedef enum logic [1:0] {
    ST_RUN      = 2'b00,
    ST_LU_STALL = 2'b01,
    ST_MEM_WAIT = 2'b10
  } hz_state_e;

  typedef struct packed {
    logic      valid;
    reg_addr_t dest;
    logic      wr;
    logic      load;
  } ex_rec_t;

  // One source operand collides with the tracked EX destination.
  function automatic logic src_hit(input logic used, input reg_addr_t src,
                                   input reg_addr_t dest);
    return used & (src == dest);
  endfunction

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating up-counter used for the stall performance counter; holds at
// all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc_en_i,
  output logic [W-1:0] count_o
);

  localparam logic [W-1:0] CNT_MAX = {W{1'b1}};
  localparam logic [W-1:0] CNT_ONE = {{(W-1){1'b0}}, 1'b1};

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Next count: step only while enabled and not yet saturated.
  always_comb begin
    count_d = count_q;
    if (inc_en_i && (count_q != CNT_MAX)) begin
      count_d = count_q + CNT_ONE;
    end else begin
      count_d = count_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= {W{1'b0}};
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: tracks the instruction in EX, stalls IF/ID on
// load-use hazards (with a bubble) and on data-memory wait (without one).
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int NUM_DOMAINS = 1,
  parameter int STALL_CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   id_valid,
  input  logic [REG_ADDR_W-1:0]  op1_addr_IFID,
  input  logic [REG_ADDR_W-1:0]  op2_addr_IFID,
  input  logic                   op1_used,
  input  logic                   op2_used,
  input  logic [REG_ADDR_W-1:0]  dest_addr_IFID,
  input  logic                   reg_wr_en_IFID,
  input  logic                   load_true_IFID,
  input  logic                   mem_busy,
  input  logic                   flush,
  output logic                   stall_IF,
  output logic                   stall_ID,
  output logic                   bubble_EX,
  output logic [REG_ADDR_W-1:0]  ex_dest_addr,
  output logic                   ex_load,
  output logic [STALL_CNT_W-1:0] stall_count
);

  if (NUM_DOMAINS < 1) begin : g_no_domains
  end

  hz_state_e state_q;
  hz_state_e state_d;
  ex_rec_t   ex_q;
  ex_rec_t   ex_d;
  logic      load_use_s;
  logic      mem_wait_s;
  logic      stall_s;
  logic      bubble_s;

  // Load-use hazard against the tracked EX instruction; R0 is not special.
  always_comb begin
    load_use_s = ex_q.valid & ex_q.wr & ex_q.load & id_valid &
                 (src_hit(op1_used, op1_addr_IFID, ex_q.dest) |
                  src_hit(op2_used, op2_addr_IFID, ex_q.dest));
  end

  // A busy memory stalls even through a flush; the bubble is load-use only.
  always_comb begin
    mem_wait_s = (state_q == ST_MEM_WAIT);
    stall_s    = mem_busy | (~flush & (load_use_s | mem_wait_s));
    bubble_s   = load_use_s & ~mem_busy & ~flush;
  end

  // FSM next state; flush overrides everything.
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = ST_RUN;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (mem_busy) begin
            state_d = ST_MEM_WAIT;
          end else if (load_use_s) begin
            state_d = ST_LU_STALL;
          end else begin
            state_d = ST_RUN;
          end
        end
        ST_LU_STALL: begin
          if (mem_busy) begin
            state_d = ST_MEM_WAIT;
          end else begin
            state_d = ST_RUN;
          end
        end
        ST_MEM_WAIT: begin
          if (mem_busy) begin
            state_d = ST_MEM_WAIT;
          end else if (load_use_s) begin
            state_d = ST_LU_STALL;
          end else begin
            state_d = ST_RUN;
          end
        end
        default: state_d = ST_RUN;
      endcase
    end
  end

  // EX shadow record: cleared by flush/bubble/idle, held through memory wait.
  always_comb begin
    ex_d = ex_q;
    if (flush | bubble_s) begin
      ex_d.valid = 1'b0;
    end else if (stall_s) begin
      ex_d = ex_q;
    end else if (id_valid) begin
      ex_d.valid = 1'b1;
      ex_d.dest  = dest_addr_IFID;
      ex_d.wr    = reg_wr_en_IFID;
      ex_d.load  = load_true_IFID;
    end else begin
      ex_d.valid = 1'b0;
    end
  end

  // FSM state and EX record registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_RUN;
      ex_q.valid <= 1'b0;
      ex_q.dest  <= 3'd0;
      ex_q.wr    <= 1'b0;
      ex_q.load  <= 1'b0;
    end else begin
      state_q <= state_d;
      ex_q    <= ex_d;
    end
  end

  sat_counter #(
    .W(STALL_CNT_W)
  ) u_stall_cnt (
    .clk     (clk),
    .rst     (rst),
    .inc_en_i(stall_s),
    .count_o (stall_count)
  );

  assign stall_IF     = stall_s;
  assign stall_ID     = stall_s;
  assign bubble_EX    = bubble_s;
  assign ex_dest_addr = ex_q.dest;
  assign ex_load      = ex_q.load;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios with literal
// expectations plus a per-cycle comparison against a behavioural model.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid, op1_used, op2_used, reg_wr_en_IFID, load_true_IFID;
  logic       mem_busy, flush;
  logic [2:0] op1_addr_IFID, op2_addr_IFID, dest_addr_IFID;

  logic       stall_IF, stall_ID, bubble_EX, ex_load;
  logic [2:0] ex_dest_addr;
  logic [7:0] stall_count;
  logic       s4_IF, s4_ID, b4_EX, ex4_load;
  logic [2:0] ex4_dest;
  logic [3:0] cnt4;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  hazard_ctrl dut (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .op1_addr_IFID(op1_addr_IFID), .op2_addr_IFID(op2_addr_IFID),
    .op1_used(op1_used), .op2_used(op2_used),
    .dest_addr_IFID(dest_addr_IFID), .reg_wr_en_IFID(reg_wr_en_IFID),
    .load_true_IFID(load_true_IFID), .mem_busy(mem_busy), .flush(flush),
    .stall_IF(stall_IF), .stall_ID(stall_ID), .bubble_EX(bubble_EX),
    .ex_dest_addr(ex_dest_addr), .ex_load(ex_load), .stall_count(stall_count)
  );

  hazard_ctrl #(.NUM_DOMAINS(1), .STALL_CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .op1_addr_IFID(op1_addr_IFID), .op2_addr_IFID(op2_addr_IFID),
    .op1_used(op1_used), .op2_used(op2_used),
    .dest_addr_IFID(dest_addr_IFID), .reg_wr_en_IFID(reg_wr_en_IFID),
    .load_true_IFID(load_true_IFID), .mem_busy(mem_busy), .flush(flush),
    .stall_IF(s4_IF), .stall_ID(s4_ID), .bubble_EX(b4_EX),
    .ex_dest_addr(ex4_dest), .ex_load(ex4_load), .stall_count(cnt4)
  );

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // EX contents as seen by the hazard unit, plus "memory was busy last edge".
  bit       m_valid = 1'b0, m_wr = 1'b0, m_load = 1'b0, m_after_busy = 1'b0;
  bit [2:0] m_dest = 3'd0;
  int       m_cnt8 = 0, m_cnt4 = 0;

  function automatic bit m_hazard();
    bit hit1, hit2;
    hit1 = op1_used && (op1_addr_IFID == m_dest);
    hit2 = op2_used && (op2_addr_IFID == m_dest);
    return m_valid && m_wr && m_load && id_valid && (hit1 || hit2);
  endfunction

  function automatic bit m_stall();
    if (mem_busy) return 1'b1;
    if (flush) return 1'b0;
    return m_hazard() || m_after_busy;
  endfunction

  function automatic bit m_bubble();
    return m_hazard() && !mem_busy && !flush;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid = 1'b0; m_wr = 1'b0; m_load = 1'b0; m_dest = 3'd0;
      m_after_busy = 1'b0; m_cnt8 = 0; m_cnt4 = 0;
    end else begin
      bit st, bb;
      st = m_stall();
      bb = m_bubble();
      if (st) begin
        m_cnt8 = (m_cnt8 < 255) ? m_cnt8 + 1 : 255;
        m_cnt4 = (m_cnt4 < 15) ? m_cnt4 + 1 : 15;
      end
      if (flush || bb) m_valid = 1'b0;
      else if (st) m_valid = m_valid;
      else if (id_valid) begin
        m_valid = 1'b1; m_dest = dest_addr_IFID;
        m_wr = reg_wr_en_IFID; m_load = load_true_IFID;
      end else m_valid = 1'b0;
      m_after_busy = mem_busy && !flush;
    end
  end

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    chk("stall_IF", int'(stall_IF), int'(m_stall()));
    chk("stall_ID", int'(stall_ID), int'(m_stall()));
    chk("bubble_EX", int'(bubble_EX), int'(m_bubble()));
    chk("ex_dest_addr", int'(ex_dest_addr), int'(m_dest));
    chk("ex_load", int'(ex_load), int'(m_load));
    chk("stall_count", int'(stall_count), m_cnt8);
    chk("w4_stall_IF", int'(s4_IF), int'(m_stall()));
    chk("w4_bubble_EX", int'(b4_EX), int'(m_bubble()));
    chk("w4_stall_count", int'(cnt4), m_cnt4);
  end

  // ---------------- stimulus ----------------
  task automatic idle();
    id_valid = 1'b0; op1_addr_IFID = 3'd0; op2_addr_IFID = 3'd0;
    op1_used = 1'b0; op2_used = 1'b0; dest_addr_IFID = 3'd0;
    reg_wr_en_IFID = 1'b0; load_true_IFID = 1'b0;
    mem_busy = 1'b0; flush = 1'b0;
  endtask

  task automatic set_id(input bit v, input bit [2:0] o1, input bit [2:0] o2,
                        input bit u1, input bit u2, input bit [2:0] d,
                        input bit wr, input bit ld);
    id_valid = v; op1_addr_IFID = o1; op2_addr_IFID = o2;
    op1_used = u1; op2_used = u2; dest_addr_IFID = d;
    reg_wr_en_IFID = wr; load_true_IFID = ld;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle();
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    idle();
    cyc();
    cyc();
    chk("reset_stall_IF", int'(stall_IF), 0);
    chk("reset_bubble_EX", int'(bubble_EX), 0);
    chk("reset_count", int'(stall_count), 0);
    chk("reset_ex_dest", int'(ex_dest_addr), 0);
    chk("reset_ex_load", int'(ex_load), 0);
    rst = 1'b0;

    // load R3 ; add R1,R3 -> one bubble, add issues next cycle
    set_id(1'b1, 3'd0, 3'd0, 1'b0, 1'b0, 3'd3, 1'b1, 1'b1);
    cyc();
    set_id(1'b1, 3'd1, 3'd3, 1'b1, 1'b1, 3'd4, 1'b1, 1'b0);
    #2;
    chk("lu_stall_IF", int'(stall_IF), 1);
    chk("lu_bubble", int'(bubble_EX), 1);
    cyc();
    #2;
    chk("lu_released", int'(stall_IF), 0);
    cyc();
    #2;
    chk("lu_issued_dest", int'(ex_dest_addr), 4);
    chk("lu_issued_load", int'(ex_load), 0);
    chk("lu_count", int'(stall_count), 1);

    // load R0 ; use R0 -> still a hazard
    do_reset();
    set_id(1'b1, 3'd0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b1);
    cyc();
    set_id(1'b1, 3'd0, 3'd5, 1'b1, 1'b0, 3'd6, 1'b1, 1'b0);
    #2;
    chk("r0_stall", int'(stall_IF), 1);
    cyc();

    // load R3 ; add R1,R2 -> no stall
    do_reset();
    set_id(1'b1, 3'd0, 3'd0, 1'b0, 1'b0, 3'd3, 1'b1, 1'b1);
    cyc();
    set_id(1'b1, 3'd1, 3'd2, 1'b1, 1'b1, 3'd4, 1'b1, 1'b0);
    #2;
    chk("nodep_stall", int'(stall_IF), 0);
    cyc();
    #2;
    chk("nodep_count", int'(stall_count), 0);

    // load-use with memory busy for 3 cycles: 3 plain stalls, then 1 bubble
    do_reset();
    set_id(1'b1, 3'd0, 3'd0, 1'b0, 1'b0, 3'd3, 1'b1, 1'b1);
    cyc();
    set_id(1'b1, 3'd1, 3'd3, 1'b1, 1'b1, 3'd4, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      mem_busy = 1'b1;
      #2;
      chk("mw_stall", int'(stall_IF), 1);
      chk("mw_no_bubble", int'(bubble_EX), 0);
      cyc();
    end
    mem_busy = 1'b0;
    #2;
    chk("mw_lu_stall", int'(stall_IF), 1);
    chk("mw_lu_bubble", int'(bubble_EX), 1);
    cyc();
    #2;
    chk("mw_released", int'(stall_IF), 0);
    cyc();
    #2;
    chk("mw_count", int'(stall_count), 4);
    chk("mw_issued_dest", int'(ex_dest_addr), 4);

    // flush coincident with load-use hazard
    do_reset();
    set_id(1'b1, 3'd0, 3'd0, 1'b0, 1'b0, 3'd3, 1'b1, 1'b1);
    cyc();
    set_id(1'b1, 3'd1, 3'd3, 1'b1, 1'b1, 3'd4, 1'b1, 1'b0);
    flush = 1'b1;
    #2;
    chk("flush_stall", int'(stall_IF), 0);
    chk("flush_bubble", int'(bubble_EX), 0);
    cyc();
    flush = 1'b0;
    #2;
    chk("flush_ex_cleared", int'(stall_IF), 0);
    cyc();

    // 20 memory-stalled cycles: 4-bit counter saturates at 15
    do_reset();
    mem_busy = 1'b1;
    repeat (20) cyc();
    mem_busy = 1'b0;
    #2;
    chk("sat_w8", int'(stall_count), 20);
    chk("sat_w4", int'(cnt4), 15);
    cyc();
    #2;
    chk("sat_w8_after", int'(stall_count), 21);
    chk("sat_w4_after", int'(cnt4), 15);

    // reset pulsed while waiting on memory
    do_reset();
    set_id(1'b1, 3'd0, 3'd0, 1'b0, 1'b0, 3'd3, 1'b1, 1'b1);
    cyc();
    set_id(1'b1, 3'd1, 3'd3, 1'b1, 1'b1, 3'd4, 1'b1, 1'b0);
    mem_busy = 1'b1;
    cyc();
    cyc();
    #1;
    rst = 1'b1;
    idle();
    #1;
    chk("rst_mid_stall", int'(stall_IF), 0);
    chk("rst_mid_count", int'(stall_count), 0);
    chk("rst_mid_ex_load", int'(ex_load), 0);
    chk("rst_mid_ex_dest", int'(ex_dest_addr), 0);
    cyc();
    rst = 1'b0;
    set_id(1'b1, 3'd1, 3'd3, 1'b1, 1'b1, 3'd4, 1'b1, 1'b0);
    #2;
    chk("rst_release_run", int'(stall_IF), 0);
    cyc();
    idle();
    cyc();
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
